// File: rtl/fetch_scheduler.sv
// Round-robin hart scheduler and fetch sequencer for the barrel core.
// Optional stall counter port stall_cnt enabled by defining FETCH_PERF_EN.
module fetch_scheduler #(
    parameter int NUM_THREADS   = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
    localparam int TW = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_THREADS-1:0]   thread_en,
    output logic [ADDRESS_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0]    instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic [TW-1:0]            out_tid,
    input  logic                     redirect_valid,
    input  logic [TW-1:0]            redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic {EMPTY, FULL} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q [NUM_THREADS];
    logic [AW-1:0]   pc_d [NUM_THREADS];
    logic [TW-1:0]   rr_q, rr_d;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [AW-1:0]   opc_q;
    logic [TW-1:0]   tid_q;

    logic [TW-1:0]   sel;
    logic [TW-1:0]   scan_idx;
    logic            sel_found;
    logic            can_load;
    logic            redir_hit;
    logic            issue;
    logic            squash;
    logic [AW-1:0]   redir_pc_w;

    // Scan threads starting just after the last one served.
    always_comb begin
        sel_found = 1'b0;
        sel       = rr_q;
        scan_idx  = rr_q;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            scan_idx = rr_q + TW'(k);
            if (!sel_found && thread_en[scan_idx]) begin
                sel_found = 1'b1;
                sel       = scan_idx;
            end
        end
    end

    assign instr_addr = pc_q[sel];
    assign can_load   = !out_valid || out_ready;
    assign redir_hit  = redirect_valid && (redirect_tid == sel);
    assign issue      = sel_found && can_load && !redir_hit;
    assign squash     = out_valid && !out_ready && redirect_valid
                        && (tid_q == redirect_tid);
    assign redir_pc_w = redirect_pc & ~AW'(3);

    // Slot is consumed even when a redirect suppresses the issue.
    assign rr_d = (sel_found && can_load) ? sel : rr_q;

    // Per-thread PC: redirect wins, otherwise advance on issue.
    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            pc_d[i] = pc_q[i];
            if (redirect_valid && redirect_tid == TW'(i))
                pc_d[i] = redir_pc_w;
            else if (issue && sel == TW'(i))
                pc_d[i] = pc_q[i] + AW'(4);
        end
    end

    // Output-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Output-stage next state: load, drain or squash.
    always_comb begin
        state_d = state_q;
        if (issue)                       state_d = FULL;
        else if (out_valid && out_ready) state_d = EMPTY;
        else if (squash)                 state_d = EMPTY;
    end

    // Output-stage outputs.
    always_comb begin
        out_valid = (state_q == FULL);
        out_instr = instr_q;
        out_pc    = opc_q;
        out_tid   = tid_q;
    end

    // PCs, round-robin pointer and output payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= RESET_PC;
            rr_q    <= TW'(NUM_THREADS - 1);
            instr_q <= '0;
            opc_q   <= '0;
            tid_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= pc_d[i];
            rr_q <= rr_d;
            if (issue) begin
                instr_q <= instr;
                opc_q   <= pc_q[sel];
                tid_q   <= sel;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles decode holds off a valid instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
